vga_scanout: RTL and testbench



---
 rtl/vga_scanout_if.sv | 35 +++
 rtl/vga_scanout.sv | 130 +++++++++++++
 tb/tb_vga_scanout.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame-memory read port and VGA DAC pins of the scanout block
//
// Signals:
//   rd_addr      frame memory read address (y*160 + x), driven by the scanout
//   rd_data      frame memory data {R,G,B}, one CLOCK_50 cycle after rd_addr
//   frame_start  one-cycle pulse at the start of vertical blanking
//   VGA_*        DAC pixel clock, syncs, blank and 10-bit colour channels
// Modports: master = scanout side, slave = memory / display side.
interface vga_scanout_if;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic        frame_start;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;

    modport master (
        output rd_addr, frame_start,
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_R, VGA_G, VGA_B,
        input  rd_data
    );

    modport slave (
        input  rd_addr, frame_start,
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  VGA_R, VGA_G, VGA_B,
        output rd_data
    );
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480@60 scanout of a 160x120 3-bit frame memory with 4x4 replication
//
// Ports:
//   CLOCK_50  50 MHz system clock
//   resetn    asynchronous active-low reset
//   bus       vga_scanout_if.master: rd_addr/rd_data memory port, frame_start,
//             VGA_CLK/HS/VS/BLANK_N/SYNC_N and VGA_R/G/B DAC pins
//
// Two-stage pipeline clocked on alternate CLOCK_50 cycles (pix_en):
//   stage A issues the read address and registers visible/hsync/vsync,
//   stage B registers the memory data and the stage-A flags onto the pins,
//   so sync, blank and colour always refer to the same pixel.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input logic           CLOCK_50,
    input logic           resetn,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG_C = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END_C = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0] V_VLST_C = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG_C = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END_C = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        r_pix_en;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [14:0] r_rd_addr;
    logic        r_frame_start;
    logic        r_vis_a;
    logic        r_hs_a;
    logic        r_vs_a;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic [9:0]  r_r;
    logic [9:0]  r_g;
    logic [9:0]  r_b;

    logic        w_visible_a;
    logic        w_hs_a;
    logic        w_vs_a;
    logic        w_h_wrap;
    logic [14:0] w_row;
    logic [14:0] w_col;
    logic [14:0] w_addr_a;

    assign w_visible_a = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_hs_a      = ~((r_h_cnt >= HS_BEG_C) && (r_h_cnt <= HS_END_C));
    assign w_vs_a      = ~((r_v_cnt >= VS_BEG_C) && (r_v_cnt <= VS_END_C));
    assign w_h_wrap    = (r_h_cnt == H_LAST_C);

    // row*160 as (row<<7)+(row<<5); the largest result (119*160+159) fits 15 bits
    assign w_row    = {7'd0, r_v_cnt[9:2]};
    assign w_col    = {7'd0, r_h_cnt[9:2]};
    assign w_addr_a = (w_row << 7) + (w_row << 5) + w_col;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pix_en      <= 1'b0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_rd_addr     <= 15'd0;
            r_frame_start <= 1'b0;
            r_vis_a       <= 1'b0;
            r_hs_a        <= 1'b1;
            r_vs_a        <= 1'b1;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_r           <= 10'd0;
            r_g           <= 10'd0;
            r_b           <= 10'd0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                if (w_h_wrap) begin
                    r_h_cnt <= 10'd0;
                    r_v_cnt <= (r_v_cnt == V_LAST_C) ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
                // pulse on the step from the last visible pixel into vertical blanking
                r_frame_start <= w_h_wrap && (r_v_cnt == V_VLST_C);

                // stage A
                r_rd_addr <= w_visible_a ? w_addr_a : 15'd0;
                r_vis_a   <= w_visible_a;
                r_hs_a    <= w_hs_a;
                r_vs_a    <= w_vs_a;

                // stage B: rd_data was returned on the intervening pix_en=0 cycle
                r_hs      <= r_hs_a;
                r_vs      <= r_vs_a;
                r_blank_n <= r_vis_a;
                r_r       <= r_vis_a ? {10{bus.rd_data[2]}} : 10'd0;
                r_g       <= r_vis_a ? {10{bus.rd_data[1]}} : 10'd0;
                r_b       <= r_vis_a ? {10{bus.rd_data[0]}} : 10'd0;
            end
        end
    end

    // pixel clock rises on the idle cycle, i.e. mid-pixel relative to pin updates
    assign bus.VGA_CLK     = r_pix_en;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.frame_start = r_frame_start;
    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_BLANK_N = r_blank_n;
    assign bus.VGA_SYNC_N  = 1'b1;
    assign bus.VGA_R       = r_r;
    assign bus.VGA_G       = r_g;
    assign bus.VGA_B       = r_b;
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout (vertical timing shortened to 15 lines)
module tb_vga_scanout;
    localparam int VVIS = 8;
    localparam int VFP  = 2;
    localparam int VSY  = 2;
    localparam int VBP  = 3;
    localparam int VTOT = VVIS + VFP + VSY + VBP;
    localparam int HTOT = 800;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    vga_scanout_if bus ();

    vga_scanout #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(VVIS), .V_FRONT(VFP), .V_SYNC(VSY), .V_BACK(VBP)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    // n = CLOCK_50 edges since reset release; edge 1 raises pix_en, edge 2 is the first stage A
    int n;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) n <= 0;
        else         n <= n + 1;
    end

    // memory: valid data only on the cycle after an address issue, garbage otherwise
    logic red_mode = 1'b0;
    always @(posedge clk) begin
        if (resetn && n >= 2 && (n % 2) == 0)
            bus.rd_data <= red_mode ? 3'b100 : bus.rd_addr[2:0];
        else
            bus.rd_data <= 3'($urandom_range(0, 7));
    end

    typedef struct {
        logic [14:0] addr;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [2:0]  col;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic [14:0] addr;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [2:0]  col;
    } vec_t;

    int   vec = 0;
    int   bad = 0;
    exp_t q[$];
    vec_t tbl[15];
    int   ta = 0;
    int   tp = 0;
    int   hs_falls[$];
    int   hs_rises[$];
    int   vs_falls[$];
    int   vs_rises[$];
    int   fs_times[$];
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    logic restarted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic chk_pins(input string tag, input logic hs, input logic vs,
                            input logic blank, input logic [2:0] col);
        chk({tag, "_hs"}, 32'(bus.VGA_HS), 32'(hs));
        chk({tag, "_vs"}, 32'(bus.VGA_VS), 32'(vs));
        chk({tag, "_blank_n"}, 32'(bus.VGA_BLANK_N), 32'(blank));
        chk({tag, "_r"}, 32'(bus.VGA_R), (blank && col[2]) ? 32'h3FF : 32'h0);
        chk({tag, "_g"}, 32'(bus.VGA_G), (blank && col[1]) ? 32'h3FF : 32'h0);
        chk({tag, "_b"}, 32'(bus.VGA_B), (blank && col[0]) ? 32'h3FF : 32'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'h0);
        chk({tag, "_vga_clk"}, 32'(bus.VGA_CLK), 32'h0);
        chk({tag, "_sync_n"}, 32'(bus.VGA_SYNC_N), 32'h1);
        chk_pins(tag, 1'b1, 1'b1, 1'b0, 3'b000);
    endtask

    // one negedge: scoreboard, spot-check table and edge monitors
    task automatic step();
        exp_t e;
        int   p, h, v, pa;
        logic vis;
        if (!resetn) return;
        chk("sync_n", 32'(bus.VGA_SYNC_N), 32'h1);
        if (n >= 1) chk("vga_clk", 32'(bus.VGA_CLK), 32'(n % 2));
        if (n < 4) chk_pins("pre_pipe", 1'b1, 1'b1, 1'b0, 3'b000);
        if (n >= 4 && (n % 2) == 0) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'h1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk_pins("sb", e.hs, e.vs, e.blank, e.col);
            end
        end
        if (n >= 2 && (n % 2) == 0) begin
            p   = n / 2 - 1;
            h   = p % HTOT;
            v   = (p / HTOT) % VTOT;
            vis = (h < 640) && (v < VVIS);
            e.addr  = vis ? 15'((v / 4) * 160 + h / 4) : 15'd0;
            e.hs    = !(h >= 656 && h <= 751);
            e.vs    = !(v >= VVIS + VFP && v <= VVIS + VFP + VSY - 1);
            e.blank = vis;
            e.col   = vis ? (red_mode ? 3'b100 : e.addr[2:0]) : 3'b000;
            chk("sb_rd_addr", 32'(bus.rd_addr), 32'(e.addr));
            chk("sb_frame_start", 32'(bus.frame_start), 32'(h == HTOT - 1 && v == VVIS - 1));
            q.push_back(e);
        end else begin
            chk("frame_start_idle", 32'(bus.frame_start), 32'h0);
        end

        if (ta < 15) begin
            pa = tbl[ta].v * HTOT + tbl[ta].h;
            if (n == 2 * pa + 2) begin
                chk($sformatf("tbl%0d_addr", ta), 32'(bus.rd_addr), 32'(tbl[ta].addr));
                ta++;
            end
        end
        if (tp < 15) begin
            pa = tbl[tp].v * HTOT + tbl[tp].h;
            if (n == 2 * pa + 4) begin
                chk_pins($sformatf("tbl%0d", tp), tbl[tp].hs, tbl[tp].vs, tbl[tp].blank, tbl[tp].col);
                tp++;
            end
        end

        if (restarted && n == 2) begin
            chk("restart_addr", 32'(bus.rd_addr), 32'h0);
            chk("restart_blank_lo", 32'(bus.VGA_BLANK_N), 32'h0);
        end
        if (restarted && n == 4) begin
            chk("restart_blank_hi", 32'(bus.VGA_BLANK_N), 32'h1);
            chk("restart_red", 32'(bus.VGA_R), 32'h3FF);
        end

        if (prev_hs && !bus.VGA_HS) hs_falls.push_back(n);
        if (!prev_hs && bus.VGA_HS) hs_rises.push_back(n);
        if (prev_vs && !bus.VGA_VS) vs_falls.push_back(n);
        if (!prev_vs && bus.VGA_VS) vs_rises.push_back(n);
        if (bus.frame_start) fs_times.push_back(n);
        prev_hs = bus.VGA_HS;
        prev_vs = bus.VGA_VS;
    endtask

    task automatic run_until(input int target);
        int guard = 0;
        while (n < target) begin
            @(negedge clk);
            step();
            guard++;
            if (guard > 70000) begin
                chk("run_timeout", 32'(n), 32'(target));
                break;
            end
        end
    endtask

    initial begin
        //          h    v   addr hs vs blk col
        tbl[0]  = '{0,   0,  0,   1, 1, 1, 3'd0};
        tbl[1]  = '{4,   0,  1,   1, 1, 1, 3'd1};
        tbl[2]  = '{16,  0,  4,   1, 1, 1, 3'd4};
        tbl[3]  = '{639, 0,  159, 1, 1, 1, 3'd7};
        tbl[4]  = '{640, 0,  0,   1, 1, 0, 3'd0};
        tbl[5]  = '{656, 0,  0,   0, 1, 0, 3'd0};
        tbl[6]  = '{751, 0,  0,   0, 1, 0, 3'd0};
        tbl[7]  = '{752, 0,  0,   1, 1, 0, 3'd0};
        tbl[8]  = '{0,   4,  160, 1, 1, 1, 3'd0};
        tbl[9]  = '{12,  4,  163, 1, 1, 1, 3'd3};
        tbl[10] = '{639, 7,  319, 1, 1, 1, 3'd7};
        tbl[11] = '{0,   8,  0,   1, 1, 0, 3'd0};
        tbl[12] = '{0,   10, 0,   1, 0, 0, 3'd0};
        tbl[13] = '{799, 11, 0,   1, 0, 0, 3'd0};
        tbl[14] = '{0,   12, 0,   1, 1, 0, 3'd0};

        resetn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("reset");
        end
        resetn = 1'b1;

        // frame 1 with address-pattern memory, then red everywhere from its blanking on
        run_until(13000);
        red_mode = 1'b1;
        run_until(37000);

        chk("tbl_addr_done", 32'(ta), 32'd15);
        chk("tbl_pins_done", 32'(tp), 32'd15);
        chk("hs_edges_seen", 32'(hs_falls.size() >= 2 && hs_rises.size() >= 1), 32'h1);
        if (hs_falls.size() >= 2 && hs_rises.size() >= 1) begin
            chk("hs_first_fall", 32'(hs_falls[0]), 32'd1316);
            chk("hs_width", 32'(hs_rises[0] - hs_falls[0]), 32'd192);
            chk("hs_period", 32'(hs_falls[1] - hs_falls[0]), 32'd1600);
        end
        chk("vs_edges_seen", 32'(vs_falls.size() >= 1 && vs_rises.size() >= 1), 32'h1);
        if (vs_falls.size() >= 1 && vs_rises.size() >= 1) begin
            chk("vs_fall", 32'(vs_falls[0]), 32'd16004);
            chk("vs_width", 32'(vs_rises[0] - vs_falls[0]), 32'd3200);
        end
        chk("frame_start_count", 32'(fs_times.size()), 32'd2);
        if (fs_times.size() == 2) begin
            chk("frame_start_first", 32'(fs_times[0]), 32'd12800);
            chk("frame_period", 32'(fs_times[1] - fs_times[0]), 32'd24000);
        end

        // reset in the middle of visible pixel (300,2) of frame 3
        run_until(2 * (2 * VTOT * HTOT + 2 * HTOT + 300) + 2);
        chk("pre_reset_visible", 32'(bus.VGA_BLANK_N), 32'h1);
        #5;
        resetn = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        chk_reset_vals("held_reset");
        q.delete();
        prev_hs   = 1'b1;
        prev_vs   = 1'b1;
        restarted = 1'b1;
        resetn    = 1'b1;
        run_until(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
